// File: rtl/ag_alu_pkg.sv
// Shared encodings and constants for the nibble-serial BCD/binary ALU.
package ag_alu_pkg;

  typedef enum logic [2:0] {
    ALU_ORA = 3'd0,
    ALU_AND = 3'd1,
    ALU_EOR = 3'd2,
    ALU_ADC = 3'd3,
    ALU_ASL = 3'd4,
    ALU_LSR = 3'd5,
    ALU_ROL = 3'd6,
    ALU_ROR = 3'd7
  } alu_op_e;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } alu_state_e;

  localparam logic [3:0] DEC_ADJ_ADD = 4'd6;
  localparam logic [3:0] DEC_ADJ_SUB = 4'd10;

endpackage

// File: rtl/ag_nibble_dec_add.sv
// One-digit adder with optional decimal correction; sub selects the borrow-style adjust.
module ag_nibble_dec_add
  import ag_alu_pkg::*;
(
  input  logic [3:0] a4,
  input  logic [3:0] b4,
  input  logic       cin,
  input  logic       d_in,
  input  logic       sub,
  output logic [3:0] digit,
  output logic       cout
);

  logic [4:0] s;
  logic       c9;

  always_comb begin
    s  = {1'b0, a4} + {1'b0, b4} + {4'b0000, cin};
    // In subtract mode the raw carry is inverted before the >9 test (no-borrow case).
    c9 = ({s[4] ^ sub, s[3:0]} > 5'd9);
    if (d_in) begin
      digit = c9 ? (s[3:0] + (sub ? DEC_ADJ_SUB : DEC_ADJ_ADD)) : s[3:0];
      cout  = c9 ^ sub;
    end else begin
      digit = s[3:0];
      cout  = s[4];
    end
  end

endmodule

// File: rtl/ag_seq_bcd_alu.sv
// Multi-cycle ALU: logic/shift ops in one RUN cycle, ADC one nibble per cycle LSB first.
// Define AG_SEQ_ALU_BIN_FAST_EN to finish binary ADC in a single RUN cycle.
module ag_seq_bcd_alu
  import ag_alu_pkg::*;
#(
  parameter int unsigned NIBBLES = 2
) (
  input  logic                 baseclk,
  input  logic                 rst,
  input  logic                 start,
  input  logic [2:0]           op,
  input  logic [4*NIBBLES-1:0] a,
  input  logic [4*NIBBLES-1:0] b,
  input  logic                 c_in,
  input  logic                 d_in,
  input  logic                 sub,
  output logic                 busy,
  output logic                 done,
  output logic [4*NIBBLES-1:0] r,
  output logic                 c_out,
  output logic                 v_out,
  output logic                 z_out,
  output logic                 n_out
);

  localparam int unsigned W    = 4 * NIBBLES;
  localparam int unsigned IdxW = (NIBBLES > 1) ? $clog2(NIBBLES) : 1;

  alu_state_e      state_q, state_d;
  alu_op_e         op_q;
  logic [W-1:0]    a_q, b_q, rsh_q, r_q;
  logic            cin_q, d_q, sub_q, carry_q;
  logic [IdxW-1:0] idx_q;
  logic            c_q, v_q, z_q, n_q;

  logic [W-1:0]    res_r;
  logic            res_c;
  logic [3:0]      nib_digit;
  logic            nib_cout;
  logic            last_nib;
  logic            fast_bin;

`ifdef AG_SEQ_ALU_BIN_FAST_EN
  assign fast_bin = ~d_q;
`else
  assign fast_bin = 1'b0;
`endif

  assign last_nib = (idx_q == IdxW'(NIBBLES - 1));

  ag_nibble_dec_add u_nib (
    .a4   (a_q[{idx_q, 2'b00} +: 4]),
    .b4   (b_q[{idx_q, 2'b00} +: 4]),
    .cin  (carry_q),
    .d_in (d_q),
    .sub  (sub_q),
    .digit(nib_digit),
    .cout (nib_cout)
  );

  always_ff @(posedge baseclk) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE, DONE: state_d = start ? RUN : IDLE;
      RUN: begin
        if (op_q != ALU_ADC || fast_bin || last_nib) state_d = DONE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    busy = (state_q == RUN);
    done = (state_q == DONE);
  end

  // Result of the current RUN cycle: whole word, or shadow with nibble idx_q filled in.
  always_comb begin
    res_r = '0;
    res_c = 1'b0;
    unique case (op_q)
      ALU_ORA: res_r = a_q | b_q;
      ALU_AND: res_r = a_q & b_q;
      ALU_EOR: res_r = a_q ^ b_q;
      ALU_ASL: {res_c, res_r} = {a_q[W-1], a_q << 1};
      ALU_LSR: {res_c, res_r} = {a_q[0], a_q >> 1};
      ALU_ROL: {res_c, res_r} = {a_q[W-1], a_q[W-2:0], cin_q};
      ALU_ROR: {res_c, res_r} = {a_q[0], cin_q, a_q[W-1:1]};
      ALU_ADC: begin
        if (fast_bin) begin
          {res_c, res_r} = {1'b0, a_q} + {1'b0, b_q} + {{W{1'b0}}, cin_q};
        end else begin
          res_r = rsh_q;
          res_r[{idx_q, 2'b00} +: 4] = nib_digit;
          res_c = nib_cout;
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge baseclk) begin
    if (rst) begin
      op_q    <= ALU_ORA;
      a_q     <= '0;
      b_q     <= '0;
      cin_q   <= 1'b0;
      d_q     <= 1'b0;
      sub_q   <= 1'b0;
      carry_q <= 1'b0;
      idx_q   <= '0;
      rsh_q   <= '0;
      r_q     <= '0;
      c_q     <= 1'b0;
      v_q     <= 1'b0;
      z_q     <= 1'b0;
      n_q     <= 1'b0;
    end else begin
      unique case (state_q)
        IDLE, DONE: begin
          if (start) begin
            op_q    <= alu_op_e'(op);
            a_q     <= a;
            b_q     <= sub ? ~b : b;
            cin_q   <= c_in;
            d_q     <= d_in;
            sub_q   <= sub;
            carry_q <= c_in;
            idx_q   <= '0;
            rsh_q   <= '0;
          end
        end
        RUN: begin
          if (state_d == DONE) begin
            r_q <= res_r;
            c_q <= res_c;
            v_q <= (op_q == ALU_ADC) && (a_q[W-1] == b_q[W-1]) && (a_q[W-1] != res_r[W-1]);
            z_q <= (res_r == '0);
            n_q <= res_r[W-1];
          end else begin
            rsh_q   <= res_r;
            carry_q <= res_c;
            idx_q   <= idx_q + 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  assign r     = r_q;
  assign c_out = c_q;
  assign v_out = v_q;
  assign z_out = z_q;
  assign n_out = n_q;

endmodule

// File: tb/tb_ag_seq_bcd_alu.sv
// Scoreboard bench: expectations queued at issue, popped and compared on each done pulse.
module tb_ag_seq_bcd_alu;

`ifdef AG_SEQ_ALU_BIN_FAST_EN
  localparam bit FastBin = 1'b1;
`else
  localparam bit FastBin = 1'b0;
`endif

  typedef struct {
    logic [7:0] r;
    logic       c, v, z, n;
    int         lat;
    int         issue;
    string      tag;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst, start, c_in, d_in, sub;
  logic [2:0]  op;
  logic [7:0]  a, b, r;
  logic        busy, done, c_out, v_out, z_out, n_out;
  logic        start4;
  logic [15:0] a4, b4, r4;
  logic        busy4, done4, c4, v4, z4, n4;

  int   cyc = 0;
  int   n_chk = 0;
  int   n_fail = 0;
  exp_t sb[$];

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  ag_seq_bcd_alu #(.NIBBLES(2)) dut (
    .baseclk(clk), .rst(rst), .start(start), .op(op), .a(a), .b(b), .c_in(c_in),
    .d_in(d_in), .sub(sub), .busy(busy), .done(done), .r(r), .c_out(c_out),
    .v_out(v_out), .z_out(z_out), .n_out(n_out)
  );

  ag_seq_bcd_alu #(.NIBBLES(4)) dut4 (
    .baseclk(clk), .rst(rst), .start(start4), .op(op), .a(a4), .b(b4), .c_in(c_in),
    .d_in(d_in), .sub(sub), .busy(busy4), .done(done4), .r(r4), .c_out(c4),
    .v_out(v4), .z_out(z4), .n_out(n4)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic int lat_of(input logic [2:0] o, input logic d);
    return (o == 3'd3 && !(FastBin && !d)) ? 3 : 2;
  endfunction

  function automatic exp_t mk(input string tag, input logic [7:0] rr, input logic c,
                              input logic v, input logic z, input logic n, input int lat);
    exp_t e;
    e.tag = tag; e.r = rr; e.c = c; e.v = v; e.z = z; e.n = n; e.lat = lat; e.issue = 0;
    return e;
  endfunction

  // Decimal ADC modelled with integer arithmetic on valid BCD operands.
  function automatic exp_t model(input logic [2:0] o, input logic [7:0] x, input logic [7:0] y,
                                 input logic c, input logic d, input logic s);
    exp_t e;
    logic [7:0] be;
    logic [8:0] t;
    int av, bv, sm;
    be = s ? ~y : y;
    e.r = '0; e.c = 1'b0;
    case (o)
      3'd0: e.r = x | be;
      3'd1: e.r = x & be;
      3'd2: e.r = x ^ be;
      3'd3: begin
        if (!d) begin
          t = {1'b0, x} + {1'b0, be} + {8'b0, c};
          e.r = t[7:0]; e.c = t[8];
        end else begin
          av = int'(x[7:4]) * 10 + int'(x[3:0]);
          bv = int'(y[7:4]) * 10 + int'(y[3:0]);
          if (!s) begin
            sm = av + bv + int'(c); e.c = (sm >= 100); sm = sm % 100;
          end else begin
            sm = av - bv - (c ? 0 : 1); e.c = (sm >= 0);
            if (sm < 0) sm += 100;
          end
          e.r = {4'(sm / 10), 4'(sm % 10)};
        end
      end
      3'd4: {e.c, e.r} = {x[7], x << 1};
      3'd5: {e.c, e.r} = {x[0], x >> 1};
      3'd6: {e.c, e.r} = {x[7], x[6:0], c};
      default: {e.c, e.r} = {x[0], c, x[7:1]};
    endcase
    e.v = (o == 3'd3) && (x[7] == be[7]) && (x[7] != e.r[7]);
    e.z = (e.r == 8'h00);
    e.n = e.r[7];
    e.lat = lat_of(o, d);
    e.tag = "rand";
    e.issue = 0;
    return e;
  endfunction

  // Caller is at a negedge; start is held for exactly one rising edge.
  task automatic issue(input logic [2:0] o, input logic [7:0] x, input logic [7:0] y,
                       input logic c, input logic d, input logic s, input exp_t e);
    op = o; a = x; b = y; c_in = c; d_in = d; sub = s; start = 1'b1;
    e.issue = cyc;
    sb.push_back(e);
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic wait_done();
    int n = 0;
    while (!done && n < 20) begin
      @(negedge clk);
      n++;
    end
    if (!done) check("done_timeout", 0, 1);
  endtask

  always @(negedge clk) begin
    if (done) begin
      if (sb.size() == 0) begin
        check("unexpected_done", 1, 0);
      end else begin
        exp_t e;
        e = sb.pop_front();
        check({e.tag, ".r"}, 32'(r), 32'(e.r));
        check({e.tag, ".c"}, 32'(c_out), 32'(e.c));
        check({e.tag, ".v"}, 32'(v_out), 32'(e.v));
        check({e.tag, ".z"}, 32'(z_out), 32'(e.z));
        check({e.tag, ".n"}, 32'(n_out), 32'(e.n));
        check({e.tag, ".lat"}, 32'(cyc - e.issue), 32'(e.lat));
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: got no finish expected finish");
    $fatal(1);
  end

  initial begin
    logic [2:0] ro;
    logic [7:0] ra, rb;
    logic       rc, rd, rs;
    int         n;

    rst = 1'b1; start = 1'b0; start4 = 1'b0; op = 3'd0; a = '0; b = '0;
    a4 = '0; b4 = '0; c_in = 1'b0; d_in = 1'b0; sub = 1'b0;
    repeat (3) @(negedge clk);
    check("rst.busy", 32'(busy), 0);
    check("rst.done", 32'(done), 0);
    check("rst.flags", 32'({c_out, v_out, z_out, n_out}), 0);
    check("rst.r", 32'(r), 0);
    rst = 1'b0;
    @(negedge clk);

    issue(3'd3, 8'h19, 8'h28, 1'b0, 1'b1, 1'b0, mk("dec_add", 8'h47, 0, 0, 0, 0, 3));
    wait_done();
    issue(3'd3, 8'h42, 8'h15, 1'b1, 1'b1, 1'b1, mk("dec_sub", 8'h27, 1, 0, 0, 0, 3));
    wait_done();
    issue(3'd3, 8'h15, 8'h42, 1'b1, 1'b1, 1'b1, mk("dec_borrow", 8'h73, 0, 0, 0, 0, 3));
    wait_done();
    @(negedge clk);
    issue(3'd3, 8'h7F, 8'h01, 1'b0, 1'b0, 1'b0,
          mk("bin_ovf", 8'h80, 0, 1, 0, 1, lat_of(3'd3, 1'b0)));
    wait_done();
    repeat (3) @(negedge clk);
    check("hold.r", 32'(r), 32'h80);

    issue(3'd7, 8'h01, 8'h00, 1'b1, 1'b0, 1'b0, mk("ror", 8'h80, 1, 0, 0, 1, 2));
    wait_done();
    issue(3'd4, 8'h81, 8'h00, 1'b0, 1'b0, 1'b0, mk("asl_b2b", 8'h02, 1, 0, 0, 0, 2));
    check("b2b.busy", 32'(busy), 1);
    wait_done();

    // Start pulsed while RUN must not disturb the op in flight.
    @(negedge clk);
    issue(3'd3, 8'h19, 8'h28, 1'b0, 1'b1, 1'b0, mk("run_start", 8'h47, 0, 0, 0, 0, 3));
    op = 3'd4; a = 8'hFF; b = 8'hFF; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    wait_done();
    repeat (3) @(negedge clk);

    issue(3'd3, 8'h55, 8'h22, 1'b0, 1'b1, 1'b0, mk("rst_mid", 8'h77, 0, 0, 0, 0, 3));
    rst = 1'b1;
    @(negedge clk);
    check("rst_mid.busy", 32'(busy), 0);
    check("rst_mid.done", 32'(done), 0);
    check("rst_mid.r", 32'(r), 0);
    check("rst_mid.flags", 32'({c_out, v_out, z_out, n_out}), 0);
    sb.delete();
    rst = 1'b0;
    @(negedge clk);
    issue(3'd0, 8'hA0, 8'h05, 1'b0, 1'b0, 1'b0, mk("post_rst", 8'hA5, 0, 0, 0, 1, 2));
    wait_done();

    for (int i = 0; i < 24; i++) begin
      ro = 3'($urandom_range(0, 7));
      rc = 1'($urandom); rd = 1'($urandom); rs = 1'($urandom);
      if (ro == 3'd3 && rd) begin
        ra = {4'($urandom_range(0, 9)), 4'($urandom_range(0, 9))};
        rb = {4'($urandom_range(0, 9)), 4'($urandom_range(0, 9))};
      end else begin
        ra = 8'($urandom); rb = 8'($urandom);
      end
      issue(ro, ra, rb, rc, rd, rs, model(ro, ra, rb, rc, rd, rs));
      wait_done();
    end

    // Four-digit decimal wrap on the wide instance.
    @(negedge clk);
    op = 3'd3; c_in = 1'b0; d_in = 1'b1; sub = 1'b0; a4 = 16'h9999; b4 = 16'h0001;
    start4 = 1'b1;
    n = 0;
    @(negedge clk);
    start4 = 1'b0;
    n = 1;
    while (!done4 && n < 20) begin
      @(negedge clk);
      n++;
    end
    check("w4.lat", 32'(n), 5);
    check("w4.r", 32'(r4), 32'h0000);
    check("w4.c", 32'(c4), 1);
    check("w4.z", 32'(z4), 1);
    check("w4.n", 32'(n4), 0);

    repeat (4) @(negedge clk);
    check("sb_empty", 32'(sb.size()), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
